// File: rtl/core_pkg.sv
// Shared core constants and the forwarding/hazard FSM encoding.
package core_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // Two-state load-use FSM; kept as plain constants so older blocks can reuse them.
  localparam logic [0:0] FH_IDLE    = 1'b0;
  localparam logic [0:0] FH_LD_WAIT = 1'b1;

  localparam logic [REGW-1:0] REG_X0 = '0;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand select for one decode source: the returning load bypass
// beats source 0 (youngest) which beats the older sources. x0 never matches.
module fwd_mux
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int REGW = core_pkg::REGW,
  parameter int NSRC = 2
) (
  input  logic [REGW-1:0]            rs,
  input  logic                       rs_en,
  input  logic [NSRC-1:0][REGW-1:0]  src_rd,
  input  logic [NSRC-1:0]            src_wen,
  input  logic [NSRC-1:0][XLEN-1:0]  src_data,
  input  logic                       byp_vld,
  input  logic [REGW-1:0]            byp_rd,
  input  logic [XLEN-1:0]            byp_data,
  output logic                       src0_hit,
  output logic                       fwd,
  output logic [XLEN-1:0]            fwd_data
);

  logic             rs_nz;
  logic [NSRC-1:0]  hit;

  assign rs_nz = (rs != REGW'(REG_X0));

  // Per-source match vector.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NSRC; i++)
      hit[i] = rs_en & src_wen[i] & (src_rd[i] == rs) & rs_nz;
  end

  assign src0_hit = hit[0];

  // Walk oldest to youngest so the youngest match overwrites; bypass last.
  always_comb begin
    fwd      = 1'b0;
    fwd_data = '0;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (hit[i]) begin
        fwd      = 1'b1;
        fwd_data = src_data[i];
      end
    end
    if (byp_vld && (byp_rd == rs) && rs_nz) begin
      fwd      = 1'b1;
      fwd_data = byp_data;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard control between decode and EX/LSU/WB.
// Load-use stalls are held by a registered wait state that tolerates any
// LSU latency and bypasses the returning load data on its release cycle.
module fwd_hazard_unit
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int REGW   = core_pkg::REGW,
  parameter int NSRC   = 2,
  parameter int LD_TMO = 15
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       dec_vld,
  input  logic [REGW-1:0]            dec_rs1,
  input  logic [REGW-1:0]            dec_rs2,
  input  logic                       dec_rs1_en,
  input  logic                       dec_rs2_en,
  input  logic [NSRC-1:0][REGW-1:0]  src_rd,
  input  logic [NSRC-1:0]            src_wen,
  input  logic [NSRC-1:0][XLEN-1:0]  src_data,
  input  logic                       ex_is_load,
  input  logic                       lsu_rvld,
  input  logic [XLEN-1:0]            lsu_rdata,
  input  logic                       flush,
  output logic                       stall,
  output logic                       rs1_fwd,
  output logic [XLEN-1:0]            rs1_fwd_data,
  output logic                       rs2_fwd,
  output logic [XLEN-1:0]            rs2_fwd_data,
  output logic                       ld_timeout,
  output logic [31:0]                stall_cnt
);

  logic [0:0]      state_q, state_d;
  logic [REGW-1:0] ld_rd_q, ld_rd_d;
  logic [7:0]      tmo_cnt_q, tmo_cnt_d;
  logic            ld_timeout_q, ld_timeout_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  logic rs1_src0_hit, rs2_src0_hit;
  logic hazard;
  logic byp_vld;

  assign byp_vld = (state_q == FH_LD_WAIT) & lsu_rvld;

  fwd_mux #(.XLEN(XLEN), .REGW(REGW), .NSRC(NSRC)) u_rs1 (
    .rs       (dec_rs1),
    .rs_en    (dec_rs1_en),
    .src_rd   (src_rd),
    .src_wen  (src_wen),
    .src_data (src_data),
    .byp_vld  (byp_vld),
    .byp_rd   (ld_rd_q),
    .byp_data (lsu_rdata),
    .src0_hit (rs1_src0_hit),
    .fwd      (rs1_fwd),
    .fwd_data (rs1_fwd_data)
  );

  fwd_mux #(.XLEN(XLEN), .REGW(REGW), .NSRC(NSRC)) u_rs2 (
    .rs       (dec_rs2),
    .rs_en    (dec_rs2_en),
    .src_rd   (src_rd),
    .src_wen  (src_wen),
    .src_data (src_data),
    .byp_vld  (byp_vld),
    .byp_rd   (ld_rd_q),
    .byp_data (lsu_rdata),
    .src0_hit (rs2_src0_hit),
    .fwd      (rs2_fwd),
    .fwd_data (rs2_fwd_data)
  );

  assign hazard = dec_vld & ex_is_load & (rs1_src0_hit | rs2_src0_hit);

  // Load-use FSM, timeout tracking and stall output; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    ld_rd_d      = ld_rd_q;
    tmo_cnt_d    = tmo_cnt_q;
    ld_timeout_d = ld_timeout_q;
    stall        = 1'b0;
    if (flush) begin
      state_d = FH_IDLE;
    end else begin
      case (state_q)
        FH_IDLE: begin
          stall = hazard;
          if (hazard) begin
            state_d   = FH_LD_WAIT;
            ld_rd_d   = src_rd[0];
            tmo_cnt_d = '0;
          end
        end
        FH_LD_WAIT: begin
          stall = ~lsu_rvld;
          if (lsu_rvld) begin
            state_d = FH_IDLE;
          end else begin
            if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
            // Sticky flag rises on the edge where the count reaches LD_TMO.
            if (tmo_cnt_q == 8'(LD_TMO - 1)) ld_timeout_d = 1'b1;
          end
        end
        default: state_d = FH_IDLE;
      endcase
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= FH_IDLE;
      ld_rd_q      <= '0;
      tmo_cnt_q    <= '0;
      ld_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ld_rd_q      <= ld_rd_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ld_timeout_q <= ld_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ld_timeout = ld_timeout_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Random and directed stimulus against a behavioural model; expectations are
// queued by the driver and compared by an independent monitor every cycle.
module tb_fwd_hazard_unit;

  localparam int XLEN   = 32;
  localparam int REGW   = 5;
  localparam int NSRC   = 2;
  localparam int LD_TMO = 15;

  logic                      CLK = 1'b0;
  logic                      RSTN;
  logic                      dec_vld;
  logic [REGW-1:0]           dec_rs1, dec_rs2;
  logic                      dec_rs1_en, dec_rs2_en;
  logic [NSRC-1:0][REGW-1:0] src_rd;
  logic [NSRC-1:0]           src_wen;
  logic [NSRC-1:0][XLEN-1:0] src_data;
  logic                      ex_is_load;
  logic                      lsu_rvld;
  logic [XLEN-1:0]           lsu_rdata;
  logic                      flush;
  logic                      stall;
  logic                      rs1_fwd, rs2_fwd;
  logic [XLEN-1:0]           rs1_fwd_data, rs2_fwd_data;
  logic                      ld_timeout;
  logic [31:0]               stall_cnt;

  fwd_hazard_unit #(.XLEN(XLEN), .REGW(REGW), .NSRC(NSRC), .LD_TMO(LD_TMO)) dut (
    .CLK(CLK), .RSTN(RSTN), .dec_vld(dec_vld), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .src_rd(src_rd), .src_wen(src_wen),
    .src_data(src_data), .ex_is_load(ex_is_load), .lsu_rvld(lsu_rvld), .lsu_rdata(lsu_rdata),
    .flush(flush), .stall(stall), .rs1_fwd(rs1_fwd), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd(rs2_fwd), .rs2_fwd_data(rs2_fwd_data), .ld_timeout(ld_timeout), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit                  vld;
    bit [REGW-1:0]       rs1, rs2;
    bit                  en1, en2;
    bit [REGW-1:0]       rd [NSRC];
    bit                  wen [NSRC];
    bit [XLEN-1:0]       data [NSRC];
    bit                  ld;
    bit                  rvld;
    bit [XLEN-1:0]       rdata;
    bit                  flush;
  } stim_t;

  typedef struct {
    bit            stall;
    bit            f1, f2;
    bit [XLEN-1:0] d1, d2;
    bit            tmo;
    bit [31:0]     scnt;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: are we waiting on a load, for which register, how long.
  bit            m_waiting;
  bit [REGW-1:0] m_ld_reg;
  int            m_wait_cycles;
  bit            m_tmo;
  longint        m_stalls;

  function automatic void model_reset();
    m_waiting = 0; m_ld_reg = 0; m_wait_cycles = 0; m_tmo = 0; m_stalls = 0;
  endfunction

  function automatic bit reads(bit en, bit [REGW-1:0] rs, bit wen, bit [REGW-1:0] rd);
    return en && wen && rs == rd && rs != 0;
  endfunction

  // First hit in age order wins: returning load, then youngest source onward.
  function automatic void operand(input stim_t s, input bit en, input bit [REGW-1:0] rs,
                                  output bit f, output bit [XLEN-1:0] d);
    f = 0; d = 0;
    if (m_waiting && s.rvld && rs == m_ld_reg && rs != 0) begin
      f = 1; d = s.rdata; return;
    end
    for (int i = 0; i < NSRC; i++)
      if (reads(en, rs, s.wen[i], s.rd[i])) begin
        f = 1; d = s.data[i]; return;
      end
  endfunction

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s.vld = 0; s.rs1 = 0; s.rs2 = 0; s.en1 = 0; s.en2 = 0;
    for (int i = 0; i < NSRC; i++) begin s.rd[i] = 0; s.wen[i] = 0; s.data[i] = 0; end
    s.ld = 0; s.rvld = 0; s.rdata = 0; s.flush = 0;
    return s;
  endfunction

  // Apply one cycle of stimulus, queue the expected response, advance the model.
  task automatic step(input stim_t s, input bit rst_low);
    exp_t e;
    bit   haz;
    @(posedge CLK); #1;
    RSTN = !rst_low;
    dec_vld = s.vld; dec_rs1 = s.rs1; dec_rs2 = s.rs2;
    dec_rs1_en = s.en1; dec_rs2_en = s.en2;
    for (int i = 0; i < NSRC; i++) begin
      src_rd[i] = s.rd[i]; src_wen[i] = s.wen[i]; src_data[i] = s.data[i];
    end
    ex_is_load = s.ld; lsu_rvld = s.rvld; lsu_rdata = s.rdata; flush = s.flush;
    if (rst_low) model_reset();

    haz = s.vld && s.ld && (reads(s.en1, s.rs1, s.wen[0], s.rd[0]) ||
                            reads(s.en2, s.rs2, s.wen[0], s.rd[0]));
    operand(s, s.en1, s.rs1, e.f1, e.d1);
    operand(s, s.en2, s.rs2, e.f2, e.d2);
    if (s.flush)          e.stall = 0;
    else if (m_waiting)   e.stall = !s.rvld;
    else                  e.stall = haz;
    e.tmo  = m_tmo;
    e.scnt = 32'(m_stalls);
    exp_q.push_back(e);

    if (!rst_low) begin
      if (e.stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (s.flush) m_waiting = 0;
      else if (m_waiting) begin
        if (s.rvld) m_waiting = 0;
        else begin
          m_wait_cycles++;
          if (m_wait_cycles >= LD_TMO) m_tmo = 1;
        end
      end else if (haz) begin
        m_waiting = 1; m_ld_reg = s.rd[0]; m_wait_cycles = 0;
      end
    end
  endtask

  task automatic peek_wait();
    @(negedge CLK); #1;
  endtask

  // Monitor: every cycle the DUT presents a response, compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", stall, e.stall);
        chk("rs1_fwd", rs1_fwd, e.f1);
        chk("rs1_fwd_data", rs1_fwd_data, e.d1);
        chk("rs2_fwd", rs2_fwd, e.f2);
        chk("rs2_fwd_data", rs2_fwd_data, e.d2);
        chk("ld_timeout", ld_timeout, e.tmo);
        chk("stall_cnt", stall_cnt, e.scnt);
      end
    end
  end

  stim_t s, ld;

  initial begin
    RSTN = 0; dec_vld = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_en = 0; dec_rs2_en = 0;
    src_rd = '0; src_wen = '0; src_data = '0; ex_is_load = 0; lsu_rvld = 0;
    lsu_rdata = 0; flush = 0;
    model_reset();
    #2;
    chk("reset_stall", stall, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_ld_timeout", ld_timeout, 0);
    step(quiet(), 1);
    step(quiet(), 1);
    step(quiet(), 0);

    // Youngest source wins.
    s = quiet(); s.vld = 1; s.rs1 = 5; s.en1 = 1;
    s.rd[0] = 5; s.wen[0] = 1; s.data[0] = 32'h11;
    s.rd[1] = 5; s.wen[1] = 1; s.data[1] = 32'h22;
    step(s, 0); peek_wait();
    chk("youngest_fwd", rs1_fwd, 1);
    chk("youngest_data", rs1_fwd_data, 32'h11);

    // x0 never forwarded.
    s = quiet(); s.vld = 1; s.rs2 = 0; s.en2 = 1;
    s.rd[0] = 0; s.wen[0] = 1; s.data[0] = 32'hFF;
    step(s, 0); peek_wait();
    chk("x0_fwd", rs2_fwd, 0);
    chk("x0_data", rs2_fwd_data, 0);

    // Load-use: detection, three waiting cycles, release with bypass.
    ld = quiet(); ld.vld = 1; ld.ld = 1; ld.rs1 = 7; ld.en1 = 1;
    ld.rd[0] = 7; ld.wen[0] = 1; ld.data[0] = 32'h1234;
    step(ld, 0);
    s = quiet(); s.vld = 1; s.rs1 = 7; s.en1 = 1;
    for (int k = 0; k < 3; k++) step(s, 0);
    s.rvld = 1; s.rdata = 32'hDEAD;
    step(s, 0); peek_wait();
    chk("byp_stall", stall, 0);
    chk("byp_data", rs1_fwd_data, 32'hDEAD);
    step(quiet(), 0); peek_wait();
    chk("stall_cnt_4", stall_cnt, 4);

    // Flush in the second wait cycle; a later lsu_rvld must be ignored.
    step(ld, 0);
    s = quiet(); s.vld = 1; s.rs1 = 7; s.en1 = 1;
    step(s, 0);
    s.flush = 1;
    step(s, 0); peek_wait();
    chk("flush_stall", stall, 0);
    s.flush = 0; s.rvld = 1; s.rdata = 32'hBEEF;
    step(s, 0); peek_wait();
    chk("post_flush_fwd", rs1_fwd, 0);
    chk("post_flush_stall", stall, 0);

    // Timeout: lsu_rvld withheld for 20 wait cycles.
    step(ld, 0);
    s = quiet(); s.vld = 1; s.rs1 = 7; s.en1 = 1;
    for (int k = 1; k <= 20; k++) begin
      step(s, 0);
      if (k == 15) begin peek_wait(); chk("tmo_15", ld_timeout, 0); end
      if (k == 16) begin peek_wait(); chk("tmo_16", ld_timeout, 1); end
    end
    s.rvld = 1; s.rdata = 32'h55;
    step(s, 0);
    step(quiet(), 0); peek_wait();
    chk("tmo_sticky", ld_timeout, 1);

    // Asynchronous reset mid-wait, then a fresh hazard.
    step(ld, 0);
    s = quiet();
    step(s, 0);
    step(s, 0);
    step(s, 1); peek_wait();
    chk("rst_stall", stall, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_tmo", ld_timeout, 0);
    step(quiet(), 0);
    step(ld, 0); peek_wait();
    chk("post_rst_hazard", stall, 1);
    s = quiet(); s.rvld = 1;
    step(s, 0);

    // Random traffic over a small register set to provoke overlaps.
    for (int n = 0; n < 3000; n++) begin
      s = quiet();
      s.vld = ($urandom_range(0, 9) < 8);
      s.rs1 = REGW'($urandom_range(0, 3)); s.rs2 = REGW'($urandom_range(0, 3));
      s.en1 = $urandom_range(0, 3) != 0;   s.en2 = $urandom_range(0, 3) != 0;
      for (int i = 0; i < NSRC; i++) begin
        s.rd[i] = REGW'($urandom_range(0, 3)); s.wen[i] = $urandom_range(0, 1);
        s.data[i] = $urandom;
      end
      s.ld = ($urandom_range(0, 9) < 3);
      s.rvld = ($urandom_range(0, 9) < 2);
      s.rdata = $urandom;
      s.flush = ($urandom_range(0, 19) == 0);
      step(s, ($urandom_range(0, 499) == 0));
    end

    @(negedge CLK); #1;
    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the RV32I core pipeline, sitting between decode and the execute/LSU/write-back stages. It selects the youngest in-flight producer for each decode source operand across `NSRC` forwarding sources. It never forwards x0. It stalls decode on a load-use hazard through a registered wait state machine that tolerates variable LSU read latency and bypasses the returning load data. It also provides a flush path, a load-timeout flag and a stall performance counter.

## Interface
- `XLEN`, 32, datapath width
- `REGW`, 5, register index width
- `NSRC`, 2, number of forwarding sources; index 0 = youngest (EX), NSRC-1 = oldest (WB)
- `LD_TMO`, 15, LD_WAIT cycles before `ld_timeout` sets; range 1..255
- `CLK`  in  1  clock
- `RSTN`  in  1  reset, asynchronous, active-low
- `dec_vld`  in  1  decode slot holds a valid instruction
- `dec_rs1` / `dec_rs2`  in  REGW  source indices
- `dec_rs1_en` / `dec_rs2_en`  in  1  source actually read
- `src_rd`  in  NSRC*REGW  destination per source, slice i = source i
- `src_wen`  in  NSRC  write-enable per source
- `src_data`  in  NSRC*XLEN  result per source
- `ex_is_load`  in  1  source 0 is a load (data not yet available)
- `lsu_rvld`  in  1  load data valid, single-cycle pulse
- `lsu_rdata`  in  XLEN  load data
- `flush`  in  1  pipeline flush (branch/trap)
- `stall`  out  1  hold decode, insert bubble
- `rs1_fwd` / `rs2_fwd`  out  1  operand replaced by forwarded value
- `rs1_fwd_data` / `rs2_fwd_data`  out  XLEN  forwarded value, 0 when not forwarding
- `ld_timeout`  out  1  sticky: load wait exceeded LD_TMO
- `stall_cnt`  out  32  saturating count of stall cycles

## Operation
- Match(s,i) = `dec_rsX_en` & `src_wen[i]` & `src_rd[i]`==rsX & rsX != 0.
- Forward select per operand, priority: load bypass (LD_WAIT & `lsu_rvld` & rsX==`ld_rd`) > source 0 > ... > source NSRC-1. `rsX_fwd` = any match; data = winning value, else 0.
- Hazard = `dec_vld` & `ex_is_load` & (Match(rs1,0) | Match(rs2,0)).
- FSM states IDLE, LD_WAIT:
  - IDLE: `stall` = hazard. On hazard, capture `ld_rd`=`src_rd[0]`, clear timeout counter, go LD_WAIT. `lsu_rvld` is ignored in IDLE.
  - LD_WAIT: `stall`=1 while `lsu_rvld`=0. Timeout counter increments (saturating). On reaching LD_TMO, `ld_timeout` sets and remains set until reset; waiting continues. On `lsu_rvld`, `stall`=0, bypass active, go IDLE.
  - `flush` in either state forces `stall`=0 that cycle and IDLE next. Flush beats hazard and `lsu_rvld` in the same cycle.
- While stalled, forward outputs still evaluate normally; `stall` dominates downstream.
- `stall_cnt` increments each cycle `stall`=1 and saturates at 0xFFFFFFFF.
- Reset: state IDLE, `ld_rd`=0, timeout counter 0, `ld_timeout`=0, `stall_cnt`=0. All combinational outputs follow from these: `stall`=0 unless a hazard is present.

## Timing
- Forwarding is purely combinational, with zero-cycle latency from `src_*`/`lsu_*` to `rsX_fwd_data`.
- `stall` asserts combinationally in the detection cycle. From the next cycle it is held by the registered LD_WAIT state.
- Minimum load-use penalty is 1 cycle: detection cycle, then `lsu_rvld` in the first LD_WAIT cycle.
- `lsu_rvld` in LD_WAIT releases `stall` in that same cycle. Decode consumes the bypassed data on that edge.
- `ld_timeout` rises on the edge where the counter reaches LD_TMO. With LD_TMO=15, it is visible on the 16th LD_WAIT cycle.
- Asynchronous reset during LD_WAIT returns to IDLE immediately and deasserts `stall`.

## Structure
- Shared package `core_pkg`: `XLEN`, `REGW`, FSM state encoding `FH_IDLE`/`FH_LD_WAIT`, constant `REG_X0`.
- One sub-module, `fwd_mux`, instantiated twice (rs1, rs2). It holds the parametrised priority match/select over NSRC sources plus the bypass input.
- The FSM, timeout counter and perf counter live in the top.

## Test plan
- NSRC=2, src0 rd=5 wen data=0x11, src1 rd=5 wen data=0x22, rs1=5 -> `rs1_fwd`=1, data 0x11 (youngest wins), `stall`=0.
- rs2=0, src0 rd=0 wen data=0xFF -> `rs2_fwd`=0, data 0.
- `ex_is_load`, src0 rd=7, rs1=7, `lsu_rvld` arrives 3 cycles later with 0xDEAD -> `stall` high for 4 cycles. In the release cycle `rs1_fwd_data`=0xDEAD. FSM returns to IDLE and `stall_cnt`=4.
- Load hazard, then `flush` in the 2nd LD_WAIT cycle with no `lsu_rvld` -> `stall`=0 that cycle, IDLE next, later `lsu_rvld` ignored.
- LD_TMO=15, load hazard with `lsu_rvld` withheld 20 cycles -> `ld_timeout` rises in the 16th LD_WAIT cycle and stays high after release.
- RSTN pulsed low mid-LD_WAIT -> `stall`=0 and all counters 0 immediately; a new hazard afterwards is detected normally.
